// File: rtl/uart_apb_regfile.sv
// UART APB register bank.
//
// Sits behind the APB access FSM and decodes its one-cycle rd_en/wr_en strobes.
// It holds the CTRL, BAUD, INT_EN and INT_STAT registers. It also generates the
// TX FIFO push and RX FIFO pop strobes, and a registered interrupt line.
// prdata is combinational, so read data is valid in the same cycle as rd_en.
//
// Register map (word index paddr[4:2]):
//   0 CTRL RW, 1 BAUD RW, 2 TXDATA WO, 3 RXDATA RO,
//   4 STATUS RO, 5 INT_EN RW, 6 INT_STAT W1C, 7 reserved.
//
// Ports:
//   pclk, preset_n                  clock, synchronous active-low reset
//   rd_en, wr_en, paddr, pwdata     access strobes and address/data from the APB FSM
//   prdata, pslverr                 combinational read data and error response
//   uart_en..stop2, baud_div        CTRL fields and baud divisor
//   tx_wdata, tx_push, tx_full/empty     TX FIFO write side and status
//   rx_rdata, rx_pop, rx_full/empty      RX FIFO read side and status
//   ev_*                            one-cycle event pulses from the TX/RX engines
//   irq                             registered interrupt
//
// Build option: define UART_APB_PSLVERR_EN to raise pslverr on accesses to
// reserved or wrong-direction registers. When it is undefined, pslverr is
// tied to 0.
module uart_apb_regfile #(
  parameter int unsigned ADDR_W   = 5,
  parameter logic [15:0] BAUD_RST = 16'd326,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic              uart_en,
  output logic              tx_en,
  output logic              rx_en,
  output logic              par_en,
  output logic              par_odd,
  output logic              stop2,
  output logic [15:0]       baud_div,
  output logic [7:0]        tx_wdata,
  output logic              tx_push,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic [7:0]        rx_rdata,
  output logic              rx_pop,
  input  logic              rx_full,
  input  logic              rx_empty,
  input  logic              ev_tx_done,
  input  logic              ev_rx_ovr,
  input  logic              ev_par_err,
  input  logic              ev_frm_err,
  output logic              irq
);

  logic [5:0]  ctrl_q, ctrl_d;
  logic [15:0] baud_q, baud_d;
  logic [5:0]  int_en_q, int_en_d;
  logic [5:0]  int_stat_q, int_stat_d;
  logic        irq_q, irq_d;

  logic [2:0]  idx;
  logic        rd_acc;
  logic        tx_ovf_set, rx_udf_set;
  logic [5:0]  int_set, int_clr;
  logic        unused_bits;

  assign idx         = paddr[4:2];
  // A write takes priority if both strobes are asserted.
  assign rd_acc      = rd_en & ~wr_en;
  assign unused_bits = ^{paddr[1:0], pwdata[DATA_W-1:16]};

  // FIFO strobes are suppressed while the block is held in reset.
  assign tx_push    = preset_n & wr_en & (idx == 3'd2) & ~tx_full;
  assign tx_ovf_set = wr_en & (idx == 3'd2) & tx_full;
  assign rx_pop     = preset_n & rd_acc & (idx == 3'd3) & ~rx_empty;
  assign rx_udf_set = rd_acc & (idx == 3'd3) & rx_empty;
  assign tx_wdata   = pwdata[7:0];

`ifdef UART_APB_PSLVERR_EN
  // A flagged write needs no extra gating: no register decodes at those indices.
  assign pslverr = (wr_en & ((idx == 3'd7) | (idx == 3'd3) | (idx == 3'd4))) |
                   (rd_acc & ((idx == 3'd7) | (idx == 3'd2)));
`else
  assign pslverr = 1'b0;
`endif

  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      unique case (idx)
        3'd0:    prdata = DATA_W'(ctrl_q);
        3'd1:    prdata = DATA_W'(baud_q);
        3'd3:    prdata = rx_empty ? '0 : DATA_W'(rx_rdata);
        3'd4:    prdata = DATA_W'({tx_full, tx_empty, rx_full, rx_empty});
        3'd5:    prdata = DATA_W'(int_en_q);
        3'd6:    prdata = DATA_W'(int_stat_q);
        default: prdata = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    int_en_d = int_en_q;
    if (wr_en) begin
      unique case (idx)
        3'd0:    ctrl_d = pwdata[5:0];
        // The divisor must not change in the middle of a frame.
        3'd1:    if (!ctrl_q[0]) baud_d = pwdata[15:0];
        3'd5:    int_en_d = pwdata[5:0];
        default: ;
      endcase
    end
    int_set    = {rx_udf_set, tx_ovf_set, ev_frm_err, ev_par_err, ev_rx_ovr, ev_tx_done};
    int_clr    = (wr_en && idx == 3'd6) ? pwdata[5:0] : 6'd0;
    // A set and a W1C in the same cycle leave the bit set.
    int_stat_d = (int_stat_q & ~int_clr) | int_set;
    irq_d      = |(int_stat_q & int_en_q);
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      ctrl_q     <= '0;
      baud_q     <= BAUD_RST;
      int_en_q   <= '0;
      int_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      int_en_q   <= int_en_d;
      int_stat_q <= int_stat_d;
      irq_q      <= irq_d;
    end
  end

  assign {stop2, par_odd, par_en, rx_en, tx_en, uart_en} = ctrl_q;
  assign baud_div = baud_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_uart_apb_regfile.sv
module tb_uart_apb_regfile;

`ifdef UART_APB_PSLVERR_EN
  localparam bit PSLV = 1'b1;
`else
  localparam bit PSLV = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        preset_n, rd_en, wr_en;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pslverr, uart_en, tx_en, rx_en, par_en, par_odd, stop2;
  logic [15:0] baud_div;
  logic [7:0]  tx_wdata, rx_rdata;
  logic        tx_push, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
  logic        ev_tx_done, ev_rx_ovr, ev_par_err, ev_frm_err, irq;

  always #5 pclk = ~pclk;

  uart_apb_regfile dut (
    .pclk(pclk), .preset_n(preset_n), .rd_en(rd_en), .wr_en(wr_en), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr), .uart_en(uart_en), .tx_en(tx_en),
    .rx_en(rx_en), .par_en(par_en), .par_odd(par_odd), .stop2(stop2), .baud_div(baud_div),
    .tx_wdata(tx_wdata), .tx_push(tx_push), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_rdata(rx_rdata), .rx_pop(rx_pop), .rx_full(rx_full), .rx_empty(rx_empty),
    .ev_tx_done(ev_tx_done), .ev_rx_ovr(ev_rx_ovr), .ev_par_err(ev_par_err),
    .ev_frm_err(ev_frm_err), .irq(irq)
  );

  // st = {tx_full, tx_empty, rx_full, rx_empty}; ev = {frm, par, rx_ovr, tx_done}
  typedef struct {
    bit          rst_n, rd, wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  st;
    logic [7:0]  rxd;
    logic [3:0]  ev;
    logic [31:0] e_prdata;
    bit          e_push, e_pop, e_err;
    logic [5:0]  e_ctrl;
    logic [15:0] e_baud;
    bit          e_irq;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  logic [5:0]  m_ctrl, m_en, m_stat;
  logic [15:0] m_baud;
  bit          m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(bit rst, bit rd, bit wr, logic [4:0] a, logic [31:0] d,
                              logic [3:0] st, logic [7:0] rxd, logic [3:0] ev,
                              logic [31:0] ep, bit epush, bit epop, bit eerr,
                              logic [5:0] ec, logic [15:0] eb, bit eirq);
    vec_t v;
    v.rst_n = rst; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.st = st; v.rxd = rxd;
    v.ev = ev; v.e_prdata = ep; v.e_push = epush; v.e_pop = epop; v.e_err = eerr;
    v.e_ctrl = ec; v.e_baud = eb; v.e_irq = eirq;
    return v;
  endfunction

  // Behavioural model: one register access per cycle, described by what it reads/changes.
  function automatic vec_t model_step(input vec_t v);
    vec_t r = v;
    int   w = int'(v.addr[4:2]);
    bit   rd = v.rd && !v.wr;
    bit   bad;
    logic [5:0] set, clr;
    bad = (w == 7) || (v.wr && (w == 3 || w == 4)) || (rd && w == 2);
    r.e_err = PSLV && (v.wr || v.rd) && bad;
    r.e_prdata = 0;
    if (rd) begin
      case (w)
        0: r.e_prdata = {26'd0, m_ctrl};
        1: r.e_prdata = {16'd0, m_baud};
        3: r.e_prdata = v.st[0] ? 32'd0 : {24'd0, v.rxd};
        4: r.e_prdata = {28'd0, v.st};
        5: r.e_prdata = {26'd0, m_en};
        6: r.e_prdata = {26'd0, m_stat};
        default: r.e_prdata = 0;
      endcase
    end
    r.e_push = v.rst_n && v.wr && w == 2 && !v.st[3];
    r.e_pop  = v.rst_n && rd && w == 3 && !v.st[0];
    if (!v.rst_n) begin
      m_ctrl = 0; m_baud = 16'd326; m_en = 0; m_stat = 0; m_irq = 0;
    end else begin
      m_irq = |(m_stat & m_en);
      set = {rd && w == 3 && v.st[0], v.wr && w == 2 && v.st[3], v.ev};
      clr = (v.wr && w == 6) ? v.wdata[5:0] : 6'd0;
      if (v.wr && w == 0) m_ctrl = v.wdata[5:0];
      if (v.wr && w == 1 && !m_ctrl[0]) m_baud = v.wdata[15:0];
      if (v.wr && w == 5) m_en = v.wdata[5:0];
      m_stat = (m_stat & ~clr) | set;
    end
    r.e_ctrl = m_ctrl; r.e_baud = m_baud; r.e_irq = m_irq;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    preset_n = v.rst_n; rd_en = v.rd; wr_en = v.wr; paddr = v.addr; pwdata = v.wdata;
    {tx_full, tx_empty, rx_full, rx_empty} = v.st;
    rx_rdata = v.rxd;
    {ev_frm_err, ev_par_err, ev_rx_ovr, ev_tx_done} = v.ev;
    #2;
    chk("prdata", prdata, v.e_prdata);
    chk("tx_push", {31'd0, tx_push}, {31'd0, v.e_push});
    chk("rx_pop", {31'd0, rx_pop}, {31'd0, v.e_pop});
    chk("pslverr", {31'd0, pslverr}, {31'd0, v.e_err});
    if (v.e_push) chk("tx_wdata", {24'd0, tx_wdata}, {24'd0, v.wdata[7:0]});
    @(posedge pclk);
    #1;
    chk("ctrl", {26'd0, stop2, par_odd, par_en, rx_en, tx_en, uart_en}, {26'd0, v.e_ctrl});
    chk("baud_div", {16'd0, baud_div}, {16'd0, v.e_baud});
    chk("irq", {31'd0, irq}, {31'd0, v.e_irq});
  endtask

  localparam logic [3:0] S0 = 4'b0101;  // tx_empty, rx_empty
  localparam logic [3:0] E0 = 4'b0000;

  initial begin
    vec_t tab[$];
    vec_t v;
    int   r;
    // rst rd wr addr wdata st rxd ev | prdata push pop err ctrl baud irq
    tab.push_back(mk(0,0,0,5'h00,32'h0,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h146,0));
    tab.push_back(mk(0,0,0,5'h00,32'h0,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h146,0));
    tab.push_back(mk(1,1,0,5'h04,32'h0,S0,8'h00,E0, 32'h146,0,0,0,6'h00,16'h146,0));
    tab.push_back(mk(1,0,1,5'h00,32'h3F,S0,8'h00,E0, 32'h000,0,0,0,6'h3F,16'h146,0));
    tab.push_back(mk(1,0,1,5'h04,32'h10,S0,8'h00,E0, 32'h000,0,0,0,6'h3F,16'h146,0));
    tab.push_back(mk(1,1,0,5'h04,32'h0,S0,8'h00,E0, 32'h146,0,0,0,6'h3F,16'h146,0));
    tab.push_back(mk(1,0,1,5'h00,32'h0,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h146,0));
    tab.push_back(mk(1,0,1,5'h04,32'h10,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h08,32'hA5,S0,8'h00,E0, 32'h000,1,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,0,5'h08,32'hA5,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h08,32'hA5,4'b1001,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h18,32'h0,S0,8'h00,E0, 32'h010,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h18,32'h10,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h0C,32'h0,4'b0100,8'h5A,E0, 32'h05A,0,1,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h0C,32'h0,S0,8'h5A,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h18,32'h0,S0,8'h00,E0, 32'h020,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h18,32'h3F,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h14,32'h02,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,0,5'h00,32'h0,S0,8'h00,4'b0010, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,0,5'h00,32'h0,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,1));
    tab.push_back(mk(1,0,1,5'h18,32'h02,S0,8'h00,4'b0010, 32'h000,0,0,0,6'h00,16'h010,1));
    tab.push_back(mk(1,1,0,5'h18,32'h0,S0,8'h00,E0, 32'h002,0,0,0,6'h00,16'h010,1));
    tab.push_back(mk(1,0,1,5'h18,32'h02,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,1));
    tab.push_back(mk(1,0,0,5'h00,32'h0,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h10,32'h0,4'b1010,8'h77,E0, 32'h00A,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h1C,32'h0,S0,8'h00,E0, 32'h000,0,0,PSLV,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h1C,32'hFFFFFFFF,S0,8'h00,E0, 32'h000,0,0,PSLV,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h08,32'h0,S0,8'h00,E0, 32'h000,0,0,PSLV,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h0C,32'hFF,4'b0100,8'h33,E0, 32'h000,0,0,PSLV,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h10,32'hFF,S0,8'h00,E0, 32'h000,0,0,PSLV,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h07,32'h0,S0,8'h00,E0, 32'h010,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,1,5'h14,32'h01,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,1,0,5'h14,32'h0,S0,8'h00,E0, 32'h001,0,0,0,6'h00,16'h010,0));
    tab.push_back(mk(1,0,1,5'h00,32'h05,S0,8'h00,E0, 32'h000,0,0,0,6'h05,16'h010,0));
    tab.push_back(mk(0,0,1,5'h08,32'hA5,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h146,0));
    tab.push_back(mk(1,1,0,5'h04,32'h0,S0,8'h00,E0, 32'h146,0,0,0,6'h00,16'h146,0));
    tab.push_back(mk(1,1,0,5'h14,32'h0,S0,8'h00,E0, 32'h000,0,0,0,6'h00,16'h146,0));

    foreach (tab[i]) apply(tab[i]);

    // Randomized phase against the reference model, starting from a fresh reset.
    v = mk(0,0,0,5'h00,32'h0,S0,8'h00,E0, 32'h0,0,0,0,6'h00,16'h146,0);
    apply(model_step(v));
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      v.rst_n = ($urandom_range(0, 59) != 0);
      v.rd = (r <= 3 || r == 8);
      v.wr = (r >= 4 && r <= 8);
      if (!v.rst_n) begin
        v.rd = 0;
        v.wr = 0;
      end
      v.addr = 5'($urandom_range(0, 31));
      v.wdata = $urandom;
      v.st = 4'($urandom);
      v.rxd = 8'($urandom);
      for (int b = 0; b < 4; b++) v.ev[b] = ($urandom_range(0, 7) == 0);
      apply(model_step(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_apb_regfile.md
Name: uart_apb_regfile

Overview:
APB register bank of the UART, directly downstream of the APB access FSM. It consumes the FSM's single-cycle rd_en/wr_en strobes plus the APB address/data, and holds the control, baud and interrupt registers. It also generates push/pop strobes into the TX/RX FIFOs and a registered interrupt line. Read data is combinational so that the FSM's always-ready response completes in the ACCESS cycle.

Parameters:
ADDR_W, 5, width of paddr used for decode (word offsets 0x00-0x1C)
BAUD_RST, 16'd326, reset value of the baud divisor register
DATA_W, 32, APB data width

Ports:
pclk  in  1  APB clock
preset_n  in  1  synchronous active-low reset
rd_en  in  1  read strobe from APB FSM (one cycle per access)
wr_en  in  1  write strobe from APB FSM (one cycle per access)
paddr  in  ADDR_W  byte address; [1:0] ignored
pwdata  in  DATA_W  write data
prdata  out  DATA_W  read data, combinational, valid while rd_en=1
pslverr  out  1  error response (see Optional Feature)
uart_en / tx_en / rx_en / par_en / par_odd / stop2  out  1 each  CTRL bits [0..5]
baud_div  out  16  baud divisor
tx_wdata  out  8  byte to TX FIFO
tx_push  out  1  TX FIFO push pulse
tx_full / tx_empty  in  1 each  TX FIFO status
rx_rdata  in  8  RX FIFO head byte
rx_pop  out  1  RX FIFO pop pulse
rx_full / rx_empty  in  1 each  RX FIFO status
ev_tx_done / ev_rx_ovr / ev_par_err / ev_frm_err  in  1 each  single-cycle event pulses from the TX/RX engines
irq  out  1  interrupt, registered

Behaviour:
- Reset is synchronous and active-low on preset_n, sampled on the rising edge of pclk. On reset: CTRL=0, baud_div=BAUD_RST, INT_EN=0, INT_STAT=0, irq=0. tx_push=0, rx_pop=0, pslverr=0 and prdata=0 whenever no strobe is active.
- Register map (paddr[4:2]):
  - 0 CTRL RW [5:0]
  - 1 BAUD RW [15:0]
  - 2 TXDATA WO [7:0]
  - 3 RXDATA RO [7:0]
  - 4 STATUS RO {tx_full, tx_empty, rx_full, rx_empty}
  - 5 INT_EN RW [5:0]
  - 6 INT_STAT W1C [5:0]
  - 7 reserved
- Unused and reserved bits read 0.
- RW registers update on the pclk edge where wr_en=1; new value is visible on the outputs the following cycle.
- BAUD write is ignored while uart_en=1 (the divisor cannot change mid-frame).
- TXDATA write:
  - tx_full=0: tx_push=1 combinationally in the same cycle, tx_wdata=pwdata[7:0].
  - tx_full=1: no push; INT_STAT[4] (tx_ovf) is set.
- RXDATA read:
  - rx_empty=0: prdata={24'b0, rx_rdata}; rx_pop=1 in the same cycle.
  - rx_empty=1: prdata=0, no pop; INT_STAT[5] (rx_udf) is set.
- INT_STAT bits: [0] tx_done, [1] rx_ovr, [2] par_err, [3] frm_err, [4] tx_ovf, [5] rx_udf.
  - Each bit is sticky: set by its event, cleared by writing 1 to that bit.
  - If a set and a W1C hit the same bit in the same cycle, set wins.
- irq <= |(INT_STAT & INT_EN), registered, so 1 cycle latency from the status/enable change to irq.
- rd_en and wr_en are never both high; if both are asserted, wr_en takes priority and prdata=0.
- Reads of WO/reserved addresses return 0. Reads have no side effects except RXDATA.
- Reset asserted mid-burst: all registers return to reset values on that edge; no push/pop is issued in a reset cycle.

Optional Feature:
Macro UART_APB_PSLVERR_EN.
- Defined: pslverr=1, combinationally during the strobe, for any access to address 7, a write to RXDATA or STATUS, or a read of TXDATA. A write flagged this way changes no state.
- Undefined: pslverr is tied to 0; those accesses are silently ignored, and reads of them return 0.

Test Plan:
- Reset sync: hold preset_n=0 for 2 edges -> CTRL=0, baud_div=326, irq=0; deassert, read BAUD -> prdata=0x146.
- Write CTRL=0x3F, then BAUD=0x10 -> BAUD stays 0x146 (uart_en=1); clear CTRL, write BAUD=0x10 -> baud_div=0x10 next cycle.
- TXDATA write 0xA5 with tx_full=0 -> tx_push=1 for 1 cycle, tx_wdata=0xA5; repeat with tx_full=1 -> no push, INT_STAT=0x10.
- RX: rx_rdata=0x5A, rx_empty=0, read RXDATA -> prdata=0x5A, rx_pop=1 one cycle; with rx_empty=1 -> prdata=0, rx_pop=0, INT_STAT[5]=1.
- IRQ: INT_EN=0x02, ev_rx_ovr pulse -> irq=1 one cycle later; W1C 0x02 coinciding with a new ev_rx_ovr pulse -> bit stays 1; a W1C alone -> irq=0 next cycle.
- With UART_APB_PSLVERR_EN: write to 0x1C -> pslverr=1 and no state change; without the macro -> pslverr=0 and the read returns 0.
